// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the serial subtractor: FSM state encoding and
// the step-counter width function.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor: d = a - b - bin with borrow-out.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor diff = a - b - bin, SLICE bits per clock, LSB first.
// Optional SERIAL_SUB_SAT_EN: unsigned saturation of diff to 0 on final borrow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int SW = clog2_min1(N);
  localparam logic [SW-1:0] LAST = SW'(N - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_next;
  logic [WIDTH-1:0] diff_final;
  logic             br;
  logic [SW-1:0]    step;
  logic             a_msb;
  logic             b_msb;
  logic [SLICE:0]   chain;
  logic [SLICE-1:0] d_slice;
  logic             accept;
  logic             last_step;

  // Ripple-borrow slice: the registered borrow feeds the lowest cell.
  assign chain[0] = br;

  for (genvar i = 0; i < SLICE; i++) begin : g_cell
    full_sub_cell u_cell (
      .a    (a_sh[i]),
      .b    (b_sh[i]),
      .bin  (chain[i]),
      .d    (d_slice[i]),
      .bout (chain[i+1])
    );
  end

  // Each step's result slice lands at its final bit position in the shadow.
  always_comb begin
    shadow_next = shadow;
    shadow_next[int'(step) * SLICE +: SLICE] = d_slice;
  end

`ifdef SERIAL_SUB_SAT_EN
  assign diff_final = chain[SLICE] ? '0 : shadow_next;
`else
  assign diff_final = shadow_next;
`endif

  assign accept    = start && (state != RUN);
  assign last_step = (state == RUN) && (step == LAST);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (step == LAST) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      shadow <= '0;
      br     <= 1'b0;
      step   <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_sh   <= a;
        b_sh   <= b;
        shadow <= '0;
        br     <= bin;
        step   <= '0;
        a_msb  <= a[WIDTH-1];
        b_msb  <= b[WIDTH-1];
      end else if (state == RUN) begin
        a_sh   <= a_sh >> SLICE;
        b_sh   <= b_sh >> SLICE;
        shadow <= shadow_next;
        br     <= chain[SLICE];
        step   <= step + SW'(1);
      end
      // Overflow uses the unsaturated sign bit so it always describes a - b - bin.
      if (last_step) begin
        diff <= diff_final;
        bout <= chain[SLICE];
        ovf  <= (a_msb ^ b_msb) & (a_msb ^ shadow_next[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed scoreboard bench for serial_subtractor in three shapes:
// 8-bit/1-bit slices, 8-bit/4-bit slices and the 1-bit full-subtractor case.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 0, bin8 = 0, busy8, done8, bout8, ovf8;
  logic [7:0] a8 = 0, b8 = 0, diff8;
  logic       start4 = 0, bin4 = 0, busy4, done4, bout4, ovf4;
  logic [7:0] a4 = 0, b4 = 0, diff4;
  logic       start1 = 0, bin1 = 0, busy1, done1, bout1, ovf1;
  logic [0:0] a1 = 0, b1 = 0, diff1;

  logic [9:0] exp8_q[$];
  logic [9:0] exp4_q[$];
  logic [9:0] exp1_q[$];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .SLICE(1)) u_s8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8));

  serial_subtractor #(.WIDTH(8), .SLICE(4)) u_s4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4));

  serial_subtractor #(.WIDTH(1), .SLICE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .ovf(ovf1));

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endfunction

  // Expected {diff, bout, ovf}; saturation clears diff when the borrow is set.
  function automatic logic [9:0] ex(input logic [7:0] d, input logic bo, input logic ov);
`ifdef SERIAL_SUB_SAT_EN
    if (bo) d = 8'h00;
`endif
    return {d, bo, ov};
  endfunction

  function automatic logic [9:0] ex1(input logic d, input logic bo, input logic ov);
`ifdef SERIAL_SUB_SAT_EN
    if (bo) d = 1'b0;
`endif
    return {7'b0, d, bo, ov};
  endfunction

  function automatic logic cur_done(input int id);
    case (id)
      0:       return done8;
      1:       return done4;
      default: return done1;
    endcase
  endfunction

  function automatic logic cur_busy(input int id);
    case (id)
      0:       return busy8;
      1:       return busy4;
      default: return busy1;
    endcase
  endfunction

  function automatic void push(input int id, input logic [9:0] e);
    case (id)
      0:       exp8_q.push_back(e);
      1:       exp4_q.push_back(e);
      default: exp1_q.push_back(e);
    endcase
  endfunction

  task automatic drive(input int id, input logic st, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tbin);
    case (id)
      0: begin start8 = st; a8 = ta; b8 = tb; bin8 = tbin; end
      1: begin start4 = st; a4 = ta; b4 = tb; bin4 = tbin; end
      default: begin start1 = st; a1 = ta[0]; b1 = tb[0]; bin1 = tbin; end
    endcase
  endtask

  // Monitors: pop the oldest expectation on every done pulse.
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (exp8_q.size() == 0) chk("s8_unexpected_done", 32'd1, 32'd0);
      else chk("s8_result", {22'd0, diff8, bout8, ovf8}, {22'd0, exp8_q.pop_front()});
    end
    if (!rst && done4) begin
      if (exp4_q.size() == 0) chk("s4_unexpected_done", 32'd1, 32'd0);
      else chk("s4_result", {22'd0, diff4, bout4, ovf4}, {22'd0, exp4_q.pop_front()});
    end
    if (!rst && done1) begin
      if (exp1_q.size() == 0) chk("s1_unexpected_done", 32'd1, 32'd0);
      else chk("s1_result", {29'd0, diff1, bout1, ovf1}, {22'd0, exp1_q.pop_front()});
    end
  end

  // One transaction; mode 1 pulses start twice mid-run, which must be ignored.
  task automatic issue(input int id, input string name, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tbin, input logic [9:0] e, input int n_steps, input int mode);
    int lat;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    push(id, e);
    drive(id, 1'b1, ta, tb, tbin);
    lat = 0;
    busy_cnt = 0;
    seen = 0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (cur_done(id)) seen = 1;
      else if (cur_busy(id)) busy_cnt++;
      if (lat == 1) drive(id, 1'b0, ~ta, ~tb, ~tbin);
      if (mode == 1 && (lat == 3 || lat == 5)) drive(id, 1'b1, 8'h00, 8'h00, 1'b0);
      if (mode == 1 && (lat == 4 || lat == 6)) drive(id, 1'b0, 8'h00, 8'h00, 1'b0);
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    chk({name, "_latency"}, lat, n_steps + 1);
    chk({name, "_busy_cycles"}, busy_cnt, n_steps);
  endtask

  task automatic back_to_back();
    int cyc;
    int dones;
    int t1;
    int t2;
    @(negedge clk);
    push(0, ex(8'h02, 1'b0, 1'b0));
    drive(0, 1'b1, 8'h05, 8'h03, 1'b0);
    cyc = 0; dones = 0; t1 = 0; t2 = 0;
    while (dones < 2 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done8) begin
        dones++;
        if (dones == 1) begin
          t1 = cyc;
          push(0, ex(8'h7F, 1'b0, 1'b1));
          drive(0, 1'b1, 8'h80, 8'h01, 1'b0);
        end else begin
          t2 = cyc;
          drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
        end
      end
    end
    chk("b2b_first_latency", t1, 9);
    chk("b2b_period", t2 - t1, 9);
    @(negedge clk);
    chk("b2b_idle_after", {busy8, done8}, 2'b00);
  endtask

  task automatic reset_abort();
    @(negedge clk);
    drive(0, 1'b1, 8'h11, 8'h22, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
      if (i == 4) rst = 1'b1;
    end
    @(negedge clk);
    chk("abort_busy", busy8, 1'b0);
    chk("abort_done", done8, 1'b0);
    chk("abort_outputs", {diff8, bout8, ovf8}, 10'd0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_still_idle", {busy8, done8}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with start asserted: reset must win.
    start8 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_s8", {busy8, done8, diff8, bout8, ovf8}, 12'd0);
    chk("reset_s4", {busy4, done4, diff4, bout4, ovf4}, 12'd0);
    chk("reset_s1", {busy1, done1, diff1, bout1, ovf1}, 5'd0);
    start8 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", busy8, 1'b0);

    issue(0, "s8_05_03", 8'h05, 8'h03, 1'b0, ex(8'h02, 1'b0, 1'b0), 8, 0);
    issue(0, "s8_03_05", 8'h03, 8'h05, 1'b0, ex(8'hFE, 1'b1, 1'b0), 8, 0);
    issue(0, "s8_00_00_b", 8'h00, 8'h00, 1'b1, ex(8'hFF, 1'b1, 1'b0), 8, 0);
    issue(0, "s8_80_01", 8'h80, 8'h01, 1'b0, ex(8'h7F, 1'b0, 1'b1), 8, 0);
    issue(0, "s8_7f_ff", 8'h7F, 8'hFF, 1'b0, ex(8'h80, 1'b1, 1'b1), 8, 0);
    issue(0, "s8_a5_5a_pulse", 8'hA5, 8'h5A, 1'b0, ex(8'h4B, 1'b0, 1'b1), 8, 1);
    issue(0, "s8_ff_ff_b", 8'hFF, 8'hFF, 1'b1, ex(8'hFF, 1'b1, 1'b0), 8, 0);
    back_to_back();
    reset_abort();

    issue(1, "s4_12_34", 8'h12, 8'h34, 1'b0, ex(8'hDE, 1'b1, 1'b0), 2, 0);
    issue(1, "s4_c8_37_b", 8'hC8, 8'h37, 1'b1, ex(8'h90, 1'b0, 1'b0), 2, 0);
    issue(1, "s4_7f_80", 8'h7F, 8'h80, 1'b0, ex(8'hFF, 1'b1, 1'b1), 2, 0);
    issue(1, "s4_80_80_b", 8'h80, 8'h80, 1'b1, ex(8'hFF, 1'b1, 1'b0), 2, 0);
    issue(1, "s4_3c_0f_b", 8'h3C, 8'h0F, 1'b1, ex(8'h2C, 1'b0, 1'b0), 2, 0);

    // Full-subtractor truth table: {a,b,bin} -> {d,bout,ovf}.
    issue(2, "s1_000", 8'h0, 8'h0, 1'b0, ex1(1'b0, 1'b0, 1'b0), 1, 0);
    issue(2, "s1_001", 8'h0, 8'h0, 1'b1, ex1(1'b1, 1'b1, 1'b0), 1, 0);
    issue(2, "s1_010", 8'h0, 8'h1, 1'b0, ex1(1'b1, 1'b1, 1'b1), 1, 0);
    issue(2, "s1_011", 8'h0, 8'h1, 1'b1, ex1(1'b0, 1'b1, 1'b0), 1, 0);
    issue(2, "s1_100", 8'h1, 8'h0, 1'b0, ex1(1'b1, 1'b0, 1'b0), 1, 0);
    issue(2, "s1_101", 8'h1, 8'h0, 1'b1, ex1(1'b0, 1'b0, 1'b1), 1, 0);
    issue(2, "s1_110", 8'h1, 8'h1, 1'b0, ex1(1'b0, 1'b0, 1'b0), 1, 0);
    issue(2, "s1_111", 8'h1, 8'h1, 1'b1, ex1(1'b1, 1'b1, 1'b0), 1, 0);

    repeat (5) @(negedge clk);
    chk("s8_queue_drained", exp8_q.size(), 0);
    chk("s4_queue_drained", exp4_q.size(), 0);
    chk("s1_queue_drained", exp1_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
